// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Drives a variable-latency data-memory
// req/ack port and resolves branches. It also holds the MEM/WB register.
// Upstream is stalled while an access is outstanding. Misaligned or
// timed-out accesses are aborted and latched into a sticky error flag.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic [31:0] branch_target_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  write_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        mem_error,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out
);

  // state   | meaning
  // ST_IDLE | no access outstanding; a new aligned access raises dmem_req
  // ST_WAIT | access issued, waiting for dmem_ack; upstream frozen
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            access, misaligned, is_load, in_wait;
  logic            complete, abort, capture;

  assign access     = mem_read_in | mem_write_in;
  assign misaligned = access & (alu_result_in[1:0] != 2'b00);
  // Read and write both set is treated as a write, so no load data returns.
  assign is_load    = mem_read_in & ~mem_write_in;
  assign in_wait    = (state == ST_WAIT);

  // The request is held through WAIT; EX/MEM is frozen by stall, so
  // address, data and direction stay stable without extra registers.
  assign dmem_req   = ~reset & (in_wait | (access & ~misaligned));
  assign dmem_we    = mem_write_in;
  assign dmem_addr  = alu_result_in;
  assign dmem_wdata = write_data_in;

  // An ack on the last allowed cycle wins over the abort.
  assign abort      = in_wait & ~dmem_ack & (cnt == CNT_LAST);
  assign complete   = dmem_req & dmem_ack;
  assign stall      = dmem_req & ~dmem_ack & ~abort;

  assign pc_src     = branch_in & zero_in;
  assign pc_target  = branch_target_in;

  // Non-memory instructions flow straight through. Memory instructions
  // write back only on the completion cycle.
  assign capture    = ~access | complete;

  // State and wait-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: enter WAIT on an unacknowledged request, leave on ack or abort.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack || abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Sticky error flag: set by a misaligned access or a timeout abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_error <= 1'b0;
    end else if (abort || (misaligned && !in_wait)) begin
      mem_error <= 1'b1;
    end
  end

  // MEM/WB register: capture on completion or non-access, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (reset || !capture) begin
      mem_to_reg_out <= 1'b0;
      reg_write_out  <= 1'b0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
    end else begin
      mem_to_reg_out <= mem_to_reg_in;
      reg_write_out  <= reg_write_in;
      read_data_out  <= (complete && is_load) ? dmem_rdata : 32'h0;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with TIMEOUT=4. Each cycle the
// expected MEM/WB record is queued at drive time. It is popped and compared
// after the clock edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
  logic        branch_in, zero_in;
  logic [31:0] branch_target_in, alu_result_in, write_data_in;
  logic [4:0]  write_reg_in;
  logic        dmem_req, dmem_we, dmem_ack, stall, pc_src, mem_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc_target;
  logic        mem_to_reg_out, reg_write_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } wb_t;

  wb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  wb_t bub;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_to_reg_in    (mem_to_reg_in),
    .reg_write_in     (reg_write_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .branch_in        (branch_in),
    .branch_target_in (branch_target_in),
    .zero_in          (zero_in),
    .alu_result_in    (alu_result_in),
    .write_data_in    (write_data_in),
    .write_reg_in     (write_reg_in),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_ack         (dmem_ack),
    .stall            (stall),
    .pc_src           (pc_src),
    .pc_target        (pc_target),
    .mem_error        (mem_error),
    .mem_to_reg_out   (mem_to_reg_out),
    .reg_write_out    (reg_write_out),
    .read_data_out    (read_data_out),
    .alu_result_out   (alu_result_out),
    .write_reg_out    (write_reg_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic wb_t mk(input logic m2r, input logic rw, input logic [31:0] rd,
                             input logic [31:0] alu, input logic [4:0] wr);
    wb_t w;
    w.m2r = m2r; w.rw = rw; w.rd = rd; w.alu = alu; w.wr = wr;
    return w;
  endfunction

  task automatic set_ctl(input logic m2r, input logic rw, input logic rd, input logic wr_en);
    mem_to_reg_in = m2r;
    reg_write_in  = rw;
    mem_read_in   = rd;
    mem_write_in  = wr_en;
  endtask

  // One cycle: inputs already driven after a negedge. Check the combinational
  // port, queue the expected MEM/WB record, then compare after the posedge.
  task automatic step(input logic e_req, input logic e_stall, input logic e_we,
                      input wb_t e_wb, input logic e_err);
    wb_t exp_wb;
    #1;
    chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
    chk("stall", {31'b0, stall}, {31'b0, e_stall});
    if (e_req) begin
      chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
      chk("dmem_addr", dmem_addr, alu_result_in);
      chk("dmem_wdata", dmem_wdata, write_data_in);
    end
    sb.push_back(e_wb);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      exp_wb = sb.pop_front();
      chk("mem_to_reg_out", {31'b0, mem_to_reg_out}, {31'b0, exp_wb.m2r});
      chk("reg_write_out", {31'b0, reg_write_out}, {31'b0, exp_wb.rw});
      chk("read_data_out", read_data_out, exp_wb.rd);
      chk("alu_result_out", alu_result_out, exp_wb.alu);
      chk("write_reg_out", {27'b0, write_reg_out}, {27'b0, exp_wb.wr});
    end
    chk("mem_error", {31'b0, mem_error}, {31'b0, e_err});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bub = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
    set_ctl(0, 0, 0, 0);
    branch_in = 0; zero_in = 0; branch_target_in = 0;
    alu_result_in = 0; write_data_in = 0; write_reg_in = 0;
    dmem_rdata = 0; dmem_ack = 0;
    @(negedge clk);

    // reset with a pending aligned load: request and stall are forced low
    mem_read_in = 1; alu_result_in = 32'h100;
    step(0, 0, 0, bub, 0);
    step(0, 0, 0, bub, 0);
    reset = 1'b0;

    // plain ALU instruction flows through
    set_ctl(0, 1, 0, 0); alu_result_in = 32'h55; write_reg_in = 5'd3;
    step(0, 0, 0, mk(0, 1, 32'h0, 32'h55, 5'd3), 0);

    // zero-wait load
    set_ctl(1, 1, 1, 0); alu_result_in = 32'h100; write_reg_in = 5'd5;
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    step(1, 0, 0, mk(1, 1, 32'hDEADBEEF, 32'h100, 5'd5), 0);

    // three-cycle store: two stall bubbles, completion on the third cycle
    set_ctl(0, 0, 0, 1); alu_result_in = 32'h40; write_data_in = 32'h1234;
    write_reg_in = 5'd7; dmem_ack = 0; dmem_rdata = 32'h5555;
    step(1, 1, 1, bub, 0);
    step(1, 1, 1, bub, 0);
    dmem_ack = 1;
    step(1, 0, 1, mk(0, 0, 32'h0, 32'h40, 5'd7), 0);

    // read and write both set behaves as a write: no load data
    set_ctl(1, 1, 1, 1); alu_result_in = 32'h44; write_reg_in = 5'd8;
    dmem_rdata = 32'hAAAA5555;
    step(1, 0, 1, mk(1, 1, 32'h0, 32'h44, 5'd8), 0);

    // load acked on the last allowed cycle completes without error
    set_ctl(1, 1, 1, 0); alu_result_in = 32'h200; write_reg_in = 5'd9; dmem_ack = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, bub, 0);
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
    step(1, 0, 0, mk(1, 1, 32'h0BADF00D, 32'h200, 5'd9), 0);

    // same load without ack: abort on the fourth request cycle
    dmem_ack = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, bub, 0);
    step(1, 0, 0, bub, 1);

    // back in idle, a zero-wait load completes; the error stays set
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    step(1, 0, 0, mk(1, 1, 32'h12345678, 32'h200, 5'd9), 1);

    // reset clears the error flag
    reset = 1; set_ctl(0, 0, 0, 0); dmem_ack = 0;
    step(0, 0, 0, bub, 0);
    reset = 0;

    // misaligned load: no request, no stall, bubble, error set
    set_ctl(1, 1, 1, 0); alu_result_in = 32'h102; write_reg_in = 5'd6;
    step(0, 0, 0, bub, 1);
    set_ctl(0, 1, 0, 0); alu_result_in = 32'h66; write_reg_in = 5'd2;
    step(0, 0, 0, mk(0, 1, 32'h0, 32'h66, 5'd2), 1);

    // branch resolution is combinational
    set_ctl(0, 0, 0, 0); alu_result_in = 32'h10; write_reg_in = 5'd0;
    branch_in = 1; zero_in = 1; branch_target_in = 32'h80;
    #1;
    chk("pc_src_taken", {31'b0, pc_src}, 32'd1);
    chk("pc_target", pc_target, 32'h80);
    zero_in = 0;
    #1;
    chk("pc_src_not_taken", {31'b0, pc_src}, 32'd0);
    step(0, 0, 0, mk(0, 0, 32'h0, 32'h10, 5'd0), 1);
    branch_in = 0;

    // reset in the middle of a wait abandons the access
    reset = 1;
    step(0, 0, 0, bub, 0);
    reset = 0;
    set_ctl(1, 1, 1, 0); alu_result_in = 32'h300; write_reg_in = 5'd4; dmem_ack = 0;
    step(1, 1, 0, bub, 0);
    step(1, 1, 0, bub, 0);
    reset = 1;
    step(0, 0, 0, bub, 0);
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'hCAFE0001;
    step(1, 0, 0, mk(1, 1, 32'hCAFE0001, 32'h300, 5'd4), 0);

    // the wait counter restarts from scratch after reset
    dmem_ack = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0, bub, 0);
    step(1, 0, 0, bub, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
